// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage MIPS core: stall arbitration, precise-exception flush sequencing,
// redirect PC and stall watchdog. Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned STALL_W = 6;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WDOG_W  = 16;

  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [WORD_W-1:0]  CODE_ERET  = 32'hE;
  localparam logic [WDOG_W-1:0]  WDOG_LIM   = WDOG_W'(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0]  WDOG_MAX   = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   exc_q, exc_d;
  logic [WORD_W-1:0]   epc_q, epc_d;
  logic [WDOG_W-1:0]   cnt_q, cnt_d;
  logic                wdog_q, wdog_d;
  logic [STALL_W-1:0]  stall_c;
  logic                flush_c;
  logic [WORD_W-1:0]   new_pc_c;
  logic                exc_valid;

  assign exc_valid = (excepttype_i != '0);

  // Highest requesting stage wins.
  function automatic logic [STALL_W-1:0] arbitrate(input logic req_if, input logic req_id,
                                                   input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      exc_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  // Next state; the exception is captured only when it must wait for a data-bus drain.
  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    unique case (state_q)
      S_RUN: begin
        if (exc_valid) begin
          if (stallreq_from_mem) begin
            state_d = S_DRAIN;
            exc_d   = excepttype_i;
            epc_d   = cp0_epc_i;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      S_DRAIN: begin
        if (!stallreq_from_mem) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Combinational outputs; flush always overrides stalls and reset forces everything quiet.
  always_comb begin
    stall_c  = '0;
    flush_c  = 1'b0;
    new_pc_c = '0;
    unique case (state_q)
      S_RUN: begin
        if (exc_valid && !stallreq_from_mem) begin
          flush_c  = 1'b1;
          new_pc_c = (excepttype_i == CODE_ERET) ? cp0_epc_i : EXC_VECTOR;
        end else begin
          stall_c = arbitrate(stallreq_from_if, stallreq_from_id, stallreq_from_ex,
                              stallreq_from_mem);
        end
      end
      S_DRAIN: begin
        if (stallreq_from_mem) begin
          stall_c = STALL_MEM;
        end else begin
          flush_c  = 1'b1;
          new_pc_c = (exc_q == CODE_ERET) ? epc_q : EXC_VECTOR;
        end
      end
      S_FLUSH: begin
        // ID/EX requests and exception codes here come from bubbles.
        stall_c = arbitrate(stallreq_from_if, 1'b0, 1'b0, stallreq_from_mem);
      end
      default: stall_c = '0;
    endcase
    if (rst) begin
      stall_c  = '0;
      flush_c  = 1'b0;
      new_pc_c = '0;
    end
  end

  assign stall  = stall_c;
  assign flush  = flush_c;
  assign new_pc = new_pc_c;

  // Watchdog: saturating run-length of stalled cycles, sticky flag one edge after the limit.
  always_comb begin
    wdog_d = wdog_q | (cnt_q >= WDOG_LIM);
    if (!stall_c[0])           cnt_d = '0;
    else if (cnt_q == WDOG_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wdog_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_o = wdog_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [WORD_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c[0]) stall_cnt_q <= stall_cnt_q + WORD_W'(1);
      if (flush_c)    flush_cnt_q <= flush_cnt_q + WORD_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. Arbitrates per-stage stall requests into the `stall[5:0]` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Sequences precise-exception flushes from the MEM stage, including waiting for an in-flight data-bus access to drain. Supplies the redirect PC and a stall watchdog.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'hBFC00380: redirect PC for all exceptions except ERET.
- `WDOG_LIMIT`, default 1023: consecutive stalled cycles before the watchdog fires. Legal range 1..65535.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1). One clock; reset is synchronous and active-high.
- `stallreq_from_if`  in  1  instruction-bus busy.
- `stallreq_from_id`  in  1  load-use hazard.
- `stallreq_from_ex`  in  1  multi-cycle ALU busy (div, madd/msub).
- `stallreq_from_mem`  in  1  data-bus access in flight.
- `excepttype_i`  in  32  MEM-stage exception code; 0 means none, 32'hE means ERET.
- `cp0_epc_i`  in  32  current EPC from CP0.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = stop.
- `flush`  out  1  clears all pipeline registers and loads `new_pc`.
- `new_pc`  out  32  redirect target; valid only while `flush`=1.
- `wdog_o`  out  1  sticky stall-watchdog flag.

## Operation
- Stall arbitration, highest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- FSM states: RUN, DRAIN, FLUSH. Reset state is RUN.
- RUN:
  - Normal stall arbitration applies.
  - If `excepttype_i`≠0 and `stallreq_from_mem`=0: assert `flush`=1 and `stall`=0 this cycle, drive `new_pc`, go to FLUSH.
  - If `excepttype_i`≠0 and `stallreq_from_mem`=1: latch `excepttype_i` and `cp0_epc_i`, drive `stall`=6'b011111 and `flush`=0, go to DRAIN.
- DRAIN:
  - `stall`=6'b011111 while `stallreq_from_mem`=1. Live `excepttype_i` is ignored; the latched values are used.
  - On the first cycle with `stallreq_from_mem`=0: `flush`=1, `stall`=0, `new_pc` from the latched values, go to FLUSH.
- FLUSH (one cycle, post-flush recovery):
  - `flush`=0.
  - `stallreq_from_id`, `stallreq_from_ex` and `excepttype_i` are ignored; they originate from bubbles.
  - `stallreq_from_if` and `stallreq_from_mem` are honored normally.
  - Always returns to RUN.
- `new_pc`:
  - `cp0_epc_i` (or the latched EPC) when the code is 32'hE; otherwise `EXC_VECTOR`.
  - 0 whenever `flush`=0.
- Flush overrides every stall request in the same cycle.
- Watchdog:
  - 16-bit counter increments each cycle `stall[0]`=1 and clears when `stall[0]`=0.
  - When the count reaches `WDOG_LIMIT`, `wdog_o` is set and stays set until `rst`. The counter saturates.
- Reset values: state RUN, `stall`=0, `flush`=0, `new_pc`=0, `wdog_o`=0, latches 0, counter 0.

## Timing
- `stall`, `flush` and `new_pc` are combinational from inputs and state. Pipeline registers sample them at the same edge.
- Exception to flush latency:
  - 0 cycles in RUN with no MEM stall.
  - N cycles when `stallreq_from_mem` is held for N cycles. The flush is asserted combinationally in the first cycle `stallreq_from_mem`=0, not on the following edge.
- Exactly one `flush` cycle per exception. Back-to-back `flush` pulses are impossible because the FLUSH state is always one cycle.
- `rst` asserted during DRAIN aborts the pending flush: no `flush` pulse, state RUN on the next edge.
- `wdog_o` rises on the edge after the counter reaches `WDOG_LIMIT`.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds outputs `stall_cnt_o[31:0]` (cycles with `stall[0]`=1) and `flush_cnt_o[31:0]` (flush pulses).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Priority: `stallreq_from_id`=1 and `stallreq_from_mem`=1 together → `stall`=6'b011111; drop mem → 6'b000111; drop id → 0.
- Syscall: `excepttype_i`=32'h8 in RUN → same cycle `flush`=1, `new_pc`=32'hBFC00380, `stall`=0. Next cycle `flush`=0, `stallreq_from_ex`=1 is ignored (`stall`=0).
- ERET under MEM stall: `excepttype_i`=32'hE, `cp0_epc_i`=32'h8000_1234, `stallreq_from_mem`=1 for 3 cycles.
  - Those 3 cycles: `stall`=6'b011111, `flush`=0.
  - 4th cycle: `flush`=1, `new_pc`=32'h8000_1234, even if `cp0_epc_i` changed during DRAIN.
- Reset mid-DRAIN: enter DRAIN, then assert `rst` one cycle → no `flush` pulse ever; outputs 0; state RUN.
- Watchdog: `WDOG_LIMIT`=4.
  - `stallreq_from_if` held for 3 cycles then released → `wdog_o`=0.
  - Held for 5 cycles → `wdog_o`=1, and it stays 1 after release until `rst`.
- With `PIPE_CTRL_PERF_EN`: 7 stalled cycles and 2 exceptions → `stall_cnt_o`=7, `flush_cnt_o`=2.
